// File: rtl/spi_types.sv
// Shared types for the SPI slave endpoint: FSM states, frame configuration
// and the maximum character width.
package spi_types;

  localparam int unsigned MAX_DATA_WIDTH = 128;
  localparam int unsigned CHAR_LEN_W     = $clog2(MAX_DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic [CHAR_LEN_W-1:0] char_len;
    logic                  lsb;
    logic                  rx_neg;
    logic                  tx_neg;
  } cfg_t;

endpackage

// File: rtl/spi_pad_sync.sv
// Two-flop synchronisers for the SPI pad inputs plus registered sclk edge
// pulses (pad change to pulse is three clk).
module spi_pad_sync (
  input  logic clk,
  input  logic rst,
  input  logic ss_pad,
  input  logic sclk_pad,
  input  logic mosi_pad,
  output logic sel,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi
);

  logic [1:0] ss_q;
  logic [1:0] sclk_q;
  logic [1:0] mosi_q;
  logic       sclk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q      <= 2'b11;
      sclk_q    <= 2'b00;
      mosi_q    <= 2'b00;
      sclk_prev <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      ss_q      <= {ss_q[0], ss_pad};
      sclk_q    <= {sclk_q[0], sclk_pad};
      mosi_q    <= {mosi_q[0], mosi_pad};
      sclk_prev <= sclk_q[1];
      sclk_rise <= sclk_q[1] & ~sclk_prev;
      sclk_fall <= ~sclk_q[1] & sclk_prev;
    end
  end

  assign sel  = ~ss_q[1];
  assign mosi = mosi_q[1];

endmodule

// File: rtl/spi_slave_endpoint.sv
// SPI slave endpoint: oversampled pad inputs, frame FSM, rx/tx shift
// registers and a single-entry tx holding register.
module spi_slave_endpoint
  import spi_types::*;
#(
  parameter int unsigned SS_WIDTH    = 8,
  parameter int unsigned SLAVE_INDEX = 0,
  parameter int unsigned DATA_W      = MAX_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SS_WIDTH-1:0]       ss_pad_i,
  input  logic                      sclk_pad_i,
  input  logic                      mosi_pad_i,
  output logic                      miso_pad_o,
  input  logic [$clog2(DATA_W)-1:0] cfg_char_len,
  input  logic                      cfg_lsb,
  input  logic                      cfg_rx_neg,
  input  logic                      cfg_tx_neg,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  output logic                      frame_abort,
  output logic                      tx_underrun
);

  localparam int unsigned LEN_W = $clog2(DATA_W);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic sel, sel_prev, sclk_rise, sclk_fall, mosi;
  logic unused_ss_bits;

  spi_pad_sync u_pad_sync (
    .clk       (clk),
    .rst       (rst),
    .ss_pad    (ss_pad_i[SLAVE_INDEX]),
    .sclk_pad  (sclk_pad_i),
    .mosi_pad  (mosi_pad_i),
    .sel       (sel),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi      (mosi)
  );

  assign unused_ss_bits = ^ss_pad_i;

  state_t             state, state_d;
  cfg_t               cfg_q, cfg_d;
  logic [DATA_W-1:0]  hold_q, hold_d, shift_tx, shift_tx_d, rx_shift, rx_shift_d, rx_data_d;
  logic               hold_full, hold_full_d;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_d, cnt_v, frame_len;
  logic               miso_d, rx_valid_d, abort_d, underrun_d;
  logic               rx_edge, tx_edge;

  // Position within the word of the k-th bit on the wire.
  function automatic logic [LEN_W-1:0] bit_pos(input logic lsb, input logic [CNT_W-1:0] len,
                                               input logic [CNT_W-1:0] k);
    return lsb ? LEN_W'(k) : LEN_W'(len - k - CNT_W'(1));
  endfunction

  assign frame_len = (cfg_q.char_len == '0) ? CNT_W'(DATA_W) : CNT_W'(cfg_q.char_len);
  assign rx_edge   = cfg_q.rx_neg ? sclk_fall : sclk_rise;
  assign tx_edge   = cfg_q.tx_neg ? sclk_fall : sclk_rise;

  always_comb begin
    state_d     = state;
    cfg_d       = cfg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full;
    shift_tx_d  = shift_tx;
    rx_shift_d  = rx_shift;
    rx_data_d   = rx_data;
    bit_cnt_d   = bit_cnt;
    cnt_v       = bit_cnt;
    miso_d      = miso_pad_o;
    rx_valid_d  = 1'b0;
    abort_d     = 1'b0;
    underrun_d  = 1'b0;

    case (state)
      IDLE: begin
        miso_d = 1'b0;
        if (sel && !sel_prev) begin
          state_d = LOAD;
          cfg_d   = '{char_len: CHAR_LEN_W'(cfg_char_len), lsb: cfg_lsb,
                      rx_neg: cfg_rx_neg, tx_neg: cfg_tx_neg};
        end
      end
      LOAD: begin
        bit_cnt_d  = '0;
        rx_shift_d = '0;
        if (hold_full) begin
          shift_tx_d  = hold_q;
          hold_full_d = 1'b0;
        end else begin
          shift_tx_d = '0;
          underrun_d = 1'b1;
        end
        miso_d  = shift_tx_d[bit_pos(cfg_q.lsb, frame_len, '0)];
        state_d = SHIFT;
      end
      SHIFT: begin
        if (!sel) begin
          abort_d = 1'b1;
          miso_d  = 1'b0;
          state_d = IDLE;
        end else begin
          // Sample before launch so a shared edge sees the updated count.
          if (rx_edge) begin
            rx_shift_d[bit_pos(cfg_q.lsb, frame_len, bit_cnt)] = mosi;
            cnt_v     = bit_cnt + CNT_W'(1);
            bit_cnt_d = cnt_v;
            if (cnt_v == frame_len) begin
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
              state_d    = DONE;
            end
          end
          if (tx_edge && cnt_v != frame_len) begin
            miso_d = shift_tx[bit_pos(cfg_q.lsb, frame_len, cnt_v)];
          end
        end
      end
      DONE: begin
        if (!sel) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_valid && !hold_full) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_prev    <= 1'b0;
      cfg_q       <= '0;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      tx_ready    <= 1'b1;
      shift_tx    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      bit_cnt     <= '0;
      miso_pad_o  <= 1'b0;
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      sel_prev    <= sel;
      cfg_q       <= cfg_d;
      hold_q      <= hold_d;
      hold_full   <= hold_full_d;
      tx_ready    <= ~hold_full_d;
      shift_tx    <= shift_tx_d;
      rx_shift    <= rx_shift_d;
      rx_data     <= rx_data_d;
      bit_cnt     <= bit_cnt_d;
      miso_pad_o  <= miso_d;
      rx_valid    <= rx_valid_d;
      frame_abort <= abort_d;
      tx_underrun <= underrun_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_endpoint.sv
// Directed bench for spi_slave_endpoint: a behavioural SPI master (sclk idle
// low, 16 clk period) drives frames and checks returned data and pulses.
module tb_spi_slave_endpoint;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   ss;
  logic         sclk, mosi, miso;
  logic [6:0]   cfg_char_len;
  logic         cfg_lsb, cfg_rx_neg, cfg_tx_neg;
  logic [127:0] tx_data, rx_data;
  logic         tx_valid, tx_ready, rx_valid, frame_abort, tx_underrun;

  int   checks = 0;
  int   passed = 0;
  int   n_rxv = 0, n_abort = 0, n_under = 0;
  logic miso_seen = 1'b0;

  spi_slave_endpoint dut (
    .clk          (clk),
    .rst          (rst),
    .ss_pad_i     (ss),
    .sclk_pad_i   (sclk),
    .mosi_pad_i   (mosi),
    .miso_pad_o   (miso),
    .cfg_char_len (cfg_char_len),
    .cfg_lsb      (cfg_lsb),
    .cfg_rx_neg   (cfg_rx_neg),
    .cfg_tx_neg   (cfg_tx_neg),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_abort  (frame_abort),
    .tx_underrun  (tx_underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid)    n_rxv++;
    if (frame_abort) n_abort++;
    if (tx_underrun) n_under++;
    if (miso)        miso_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [127:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [6:0] len, input logic lsb);
    cfg_char_len = len;
    cfg_lsb      = lsb;
    cfg_rx_neg   = 1'b0;
    cfg_tx_neg   = 1'b1;
  endtask

  // Master: mosi changes on sclk fall, miso captured just before each rise.
  task automatic spi_frame(input int nbits, input int nsend, input logic [127:0] word,
                           input logic lsb, input logic [7:0] ssv, output logic [127:0] got);
    got = '0;
    ss  = ssv;
    tick(8);
    for (int k = 0; k < nsend; k++) begin
      int p;
      p    = lsb ? k : nbits - 1 - k;
      mosi = word[p];
      tick(8);
      got[p] = miso;
      sclk   = 1'b1;
      tick(8);
      sclk   = 1'b0;
    end
    tick(8);
    ss   = 8'hFF;
    mosi = 1'b0;
    tick(8);
  endtask

  task automatic test_reset;
    rst = 1'b1; ss = 8'hFF; sclk = 1'b0; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    set_cfg(7'd8, 1'b0);
    tick(3);
    checks++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", miso); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); else passed++;
    checks++; if (rx_data !== 128'h0) $display("FAIL reset_rx_data: got %h expected 0", rx_data); else passed++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else passed++;
    checks++; if (frame_abort !== 1'b0) $display("FAIL reset_abort: got %b expected 0", frame_abort); else passed++;
    checks++; if (tx_underrun !== 1'b0) $display("FAIL reset_underrun: got %b expected 0", tx_underrun); else passed++;
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_msb8;
    logic [127:0] got;
    int rxv0;
    set_cfg(7'd8, 1'b0);
    push(128'hA5);
    checks++; if (tx_ready !== 1'b0) $display("FAIL msb8_tx_ready_full: got %b expected 0", tx_ready); else passed++;
    rxv0 = n_rxv;
    spi_frame(8, 8, 128'h3C, 1'b0, 8'hFE, got);
    checks++; if (got !== 128'hA5) $display("FAIL msb8_miso: got %h expected a5", got); else passed++;
    checks++; if (n_rxv - rxv0 !== 1) $display("FAIL msb8_rx_valid_count: got %0d expected 1", n_rxv - rxv0); else passed++;
    checks++; if (rx_data !== 128'h3C) $display("FAIL msb8_rx_data: got %h expected 3c", rx_data); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL msb8_tx_ready_after: got %b expected 1", tx_ready); else passed++;
  endtask

  task automatic test_lsb16;
    logic [127:0] got;
    int rxv0;
    set_cfg(7'd16, 1'b1);
    push(128'hBEEF);
    rxv0 = n_rxv;
    spi_frame(16, 16, 128'h1234, 1'b1, 8'hFE, got);
    checks++; if (got !== 128'hBEEF) $display("FAIL lsb16_miso: got %h expected beef", got); else passed++;
    checks++; if (rx_data !== 128'h1234) $display("FAIL lsb16_rx_data: got %h expected 1234", rx_data); else passed++;
    checks++; if (n_rxv - rxv0 !== 1) $display("FAIL lsb16_rx_valid_count: got %0d expected 1", n_rxv - rxv0); else passed++;
  endtask

  task automatic test_other_ss;
    logic [127:0] got;
    int rxv0;
    set_cfg(7'd8, 1'b0);
    push(128'h55);
    rxv0 = n_rxv;
    miso_seen = 1'b0;
    spi_frame(8, 8, 128'hFF, 1'b0, 8'hFD, got);
    checks++; if (n_rxv !== rxv0) $display("FAIL other_ss_rx_valid: got %0d pulses expected 0", n_rxv - rxv0); else passed++;
    checks++; if (miso_seen !== 1'b0) $display("FAIL other_ss_miso: got miso high %b expected 0", miso_seen); else passed++;
    checks++; if (tx_ready !== 1'b0) $display("FAIL other_ss_tx_ready: got %b expected 0", tx_ready); else passed++;
    checks++; if (rx_data !== 128'h1234) $display("FAIL other_ss_rx_data: got %h expected 1234", rx_data); else passed++;
  endtask

  task automatic test_abort;
    logic [127:0] got;
    int rxv0, ab0, un0;
    set_cfg(7'd8, 1'b0);
    rxv0 = n_rxv; ab0 = n_abort;
    spi_frame(8, 5, 128'hFF, 1'b0, 8'hFE, got);
    checks++; if (n_abort - ab0 !== 1) $display("FAIL abort_pulse: got %0d expected 1", n_abort - ab0); else passed++;
    checks++; if (n_rxv !== rxv0) $display("FAIL abort_rx_valid: got %0d pulses expected 0", n_rxv - rxv0); else passed++;
    checks++; if (rx_data !== 128'h1234) $display("FAIL abort_rx_data: got %h expected 1234", rx_data); else passed++;
    checks++; if (miso !== 1'b0) $display("FAIL abort_miso: got %b expected 0", miso); else passed++;
    checks++; if (got[7:3] !== 5'b01010) $display("FAIL abort_held_word: got %b expected 01010", got[7:3]); else passed++;
    // Holding register drained by the aborted frame, so this one underruns.
    un0 = n_under; rxv0 = n_rxv;
    spi_frame(8, 8, 128'h81, 1'b0, 8'hFE, got);
    checks++; if (rx_data !== 128'h81) $display("FAIL after_abort_rx_data: got %h expected 81", rx_data); else passed++;
    checks++; if (n_under - un0 !== 1) $display("FAIL underrun_pulse: got %0d expected 1", n_under - un0); else passed++;
    checks++; if (got !== 128'h0) $display("FAIL underrun_miso: got %h expected 0", got); else passed++;
    checks++; if (n_rxv - rxv0 !== 1) $display("FAIL after_abort_rx_valid: got %0d expected 1", n_rxv - rxv0); else passed++;
  endtask

  task automatic test_full_width;
    logic [127:0] got, word;
    int rxv0;
    word = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    set_cfg(7'd0, 1'b0);
    rxv0 = n_rxv;
    spi_frame(128, 128, word, 1'b0, 8'hFE, got);
    checks++; if (n_rxv - rxv0 !== 1) $display("FAIL full_rx_valid_count: got %0d expected 1", n_rxv - rxv0); else passed++;
    checks++; if (rx_data !== word) $display("FAIL full_rx_data: got %h expected %h", rx_data, word); else passed++;
    checks++; if (got !== 128'h0) $display("FAIL full_miso: got %h expected 0", got); else passed++;
  endtask

  task automatic test_reset_midframe;
    logic [127:0] got;
    int rxv0;
    set_cfg(7'd8, 1'b0);
    push(128'hFF);
    rxv0 = n_rxv;
    ss = 8'hFE;
    tick(8);
    for (int k = 0; k < 3; k++) begin
      mosi = 1'b1; tick(8); sclk = 1'b1; tick(8); sclk = 1'b0;
    end
    tick(4);
    rst = 1'b1;
    tick(1);
    checks++; if (miso !== 1'b0) $display("FAIL midrst_miso: got %b expected 0", miso); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL midrst_tx_ready: got %b expected 1", tx_ready); else passed++;
    checks++; if (rx_data !== 128'h0) $display("FAIL midrst_rx_data: got %h expected 0", rx_data); else passed++;
    ss = 8'hFF; mosi = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(4);
    checks++; if (n_rxv !== rxv0) $display("FAIL midrst_rx_valid: got %0d pulses expected 0", n_rxv - rxv0); else passed++;
    push(128'h5A);
    spi_frame(8, 8, 128'hC3, 1'b0, 8'hFE, got);
    checks++; if (rx_data !== 128'hC3) $display("FAIL post_rst_rx_data: got %h expected c3", rx_data); else passed++;
    checks++; if (got !== 128'h5A) $display("FAIL post_rst_miso: got %h expected 5a", got); else passed++;
    checks++; if (n_rxv - rxv0 !== 1) $display("FAIL post_rst_rx_valid: got %0d expected 1", n_rxv - rxv0); else passed++;
  endtask

  initial begin
    test_reset;
    test_msb8;
    test_lsb16;
    test_other_ss;
    test_abort;
    test_full_width;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
